// File: rtl/pow2x_pkg.sv
// Shared types and constants for the pow2x fixed-point antilog unit.
// The formats are Q6.5 for the input, Q2.15 for the accumulator and Q5.11 for the output.
package pow2x_pkg;

    localparam int IN_INT_W   = 6;
    localparam int IN_FRAC_W  = 5;
    localparam int IN_W       = IN_INT_W + IN_FRAC_W;
    localparam int OUT_W      = 16;
    localparam int K_W        = 16;
    localparam int ACC_W      = 17;
    localparam int ACC_FRAC_W = 15;
    localparam int OUT_FRAC_W = 11;
    localparam int PROD_W     = ACC_W + K_W;
    localparam int CNT_W      = 3;
    localparam int FIN_SHIFT  = ACC_FRAC_W - OUT_FRAC_W;

    localparam logic [ACC_W-1:0] ONE_Q2_15 = 17'h08000;
    localparam int               OVF_LIMIT = 5;

    // Entry i is 2^(2^-(i+1)) in Q1.15. Entry 0 pairs with the fraction MSB.
    localparam logic [K_W-1:0] K [0:IN_FRAC_W-1] = '{
        16'd46341, 16'd38968, 16'd35734, 16'd34219, 16'd33486
    };

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        FIN
    } state_e;

endpackage

// File: rtl/pow2x_mulstep.sv
// One multiply step: acc * K, rounded half up and brought back to Q2.15.
// Purely combinational. The caller decides whether the result is used.
module pow2x_mulstep
    import pow2x_pkg::*;
(
    input  logic [ACC_W-1:0] acc_i,
    input  logic [K_W-1:0]   k_i,
    output logic [ACC_W-1:0] acc_o
);

    localparam logic [PROD_W-1:0] ROUND = PROD_W'(1) << (ACC_FRAC_W - 1);

    logic [PROD_W-1:0] prod;

    assign prod  = {{K_W{1'b0}}, acc_i} * {{ACC_W{1'b0}}, k_i};
    assign acc_o = ACC_W'((prod + ROUND) >> ACC_FRAC_W);

endmodule

// File: rtl/pow2x.sv
// Iterative fixed-point 2^x. It consumes one fraction bit per cycle, MSB first, then
// applies the integer part as a left shift. The latency is six cycles from start to done.
module pow2x
    import pow2x_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IN_W-1:0]  x,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] o,
    output logic             ovf
);

    state_e             state_q, state_d;
    logic [IN_W-1:0]    x_q, x_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [OUT_W-1:0]   o_q, o_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W-1:0]     acc_mul;
    logic [IN_INT_W-1:0]  int_part;
    logic [IN_FRAC_W-1:0] frac;
    logic                 frac_bit;
    logic                 last_step;

    assign int_part  = x_q[IN_W-1:IN_FRAC_W];
    assign frac      = x_q[IN_FRAC_W-1:0];
    assign frac_bit  = frac[CNT_W'(IN_FRAC_W-1) - cnt_q];
    assign last_step = (cnt_q == CNT_W'(IN_FRAC_W-1));

    pow2x_mulstep u_mulstep (
        .acc_i (acc_q),
        .k_i   (K[cnt_q]),
        .acc_o (acc_mul)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            o_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            o_q     <= o_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = MUL;
            MUL:     if (last_step) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every _d signal gets its hold value before the case statement, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        x_d    = x_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        o_d    = o_q;
        ovf_d  = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    x_d    = x;
                    acc_d  = ONE_Q2_15;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                end
            end
            MUL: begin
                if (frac_bit) acc_d = acc_mul;
                cnt_d = cnt_q + CNT_W'(1);
            end
            FIN: begin
                // The Q2.15 to Q5.11 realignment is folded into the integer shift.
                if (int_part >= IN_INT_W'(OVF_LIMIT)) begin
                    o_d   = '1;
                    ovf_d = 1'b1;
                end else begin
                    o_d   = OUT_W'(({{FIN_SHIFT{1'b0}}, acc_q} << int_part) >> FIN_SHIFT);
                    ovf_d = 1'b0;
                end
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign o    = o_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_pow2x.sv
// Scoreboard bench for pow2x. The driver predicts which starts are accepted and queues them.
// The monitor checks busy, done timing and results against real-valued 2^x on every cycle.
module tb_pow2x;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [10:0] x_in = '0;
    logic        busy, done, ovf;
    logic [15:0] o;

    pow2x dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x_in),
        .busy  (busy),
        .done  (done),
        .o     (o),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    // Index of the most recent rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [10:0] xv;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   free_edge = 0;
    bit   mon_en    = 1'b0;
    int   n_cmp     = 0;
    int   n_bad     = 0;

    task automatic check(input string name, input bit ok, input longint act, input longint req);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one start pulse. The op is expected only if the unit is idle at the sampling edge.
    task automatic do_start(input logic [10:0] v);
        @(negedge clk);
        start = 1'b1;
        x_in  = v;
        if (cyc + 1 >= free_edge) begin
            sb.push_back('{xv: v, due: cyc + 1 + 6});
            free_edge = cyc + 1 + 7;
        end
        @(negedge clk);
        start = 1'b0;
        x_in  = 11'($urandom);
    endtask

    // Return so that the next do_start lands in the done cycle of the op in flight.
    task automatic wait_idle();
        int n = 0;
        while (cyc + 2 < free_edge && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("wait_idle_timeout", 1'b0, n, 50);
    endtask

    // Monitor
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && rst) begin
                bit busy_exp;
                busy_exp = (sb.size() > 0) && (cyc < sb[0].due);
                check("busy", busy === busy_exp, busy, busy_exp);
                if (sb.size() > 0 && cyc == sb[0].due) begin
                    exp_t        e;
                    logic [10:0] xv;
                    real         ideal, diff;
                    e  = sb.pop_front();
                    xv = e.xv;
                    check("done", done === 1'b1, done, 1);
                    if (xv[10:5] >= 6'd5) begin
                        check("o_ovf", o === 16'hFFFF, o, 16'hFFFF);
                        check("ovf_set", ovf === 1'b1, ovf, 1);
                    end else begin
                        ideal = $pow(2.0, real'(xv) / 32.0) * 2048.0;
                        if (xv[4:0] == 5'd0) begin
                            check("o_exact", o === 16'(longint'(ideal)), o, longint'(ideal));
                        end else begin
                            diff = real'(o) - ideal;
                            if (diff < 0.0) diff = -diff;
                            check("o_approx", diff <= 2.0, o, longint'(ideal));
                        end
                        check("ovf_clr", ovf === 1'b0, ovf, 0);
                        if (xv == 11'd125)
                            check("round_trip", 32'(o[15:11]) + 32'(o[10]) == 15,
                                  32'(o[15:11]) + 32'(o[10]), 15);
                    end
                end else begin
                    check("no_done", done === 1'b0, done, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b0;
        #2;
        check("rst_busy", busy === 1'b0, busy, 0);
        check("rst_done", done === 1'b0, done, 0);
        check("rst_o", o === 16'h0000, o, 0);
        check("rst_ovf", ovf === 1'b0, ovf, 0);
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;

        // Directed points, each started in the done cycle of the previous op.
        do_start(11'd0);
        wait_idle(); do_start(11'd128);
        wait_idle(); do_start(11'd48);
        wait_idle(); do_start(11'd125);
        wait_idle(); do_start(11'd159);
        wait_idle(); do_start(11'd160);
        wait_idle(); do_start(11'h7FF);
        wait_idle(); do_start(11'd32);

        // A start while busy is dropped. A start in the done cycle is taken.
        wait_idle(); do_start(11'd48);
        do_start(11'd0);
        wait_idle(); do_start(11'd0);

        // Asynchronous reset in the third MUL cycle aborts the op.
        wait_idle(); do_start(11'd125);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_busy", busy === 1'b0, busy, 0);
        check("abort_done", done === 1'b0, done, 0);
        check("abort_o", o === 16'h0000, o, 0);
        check("abort_ovf", ovf === 1'b0, ovf, 0);
        sb.delete();
        free_edge = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        do_start(11'd48);

        // Random traffic. Some starts land while busy and must be dropped.
        for (int i = 0; i < 60; i++) begin
            logic [10:0] v;
            int          sel;
            repeat ($urandom_range(0, 8)) @(negedge clk);
            sel = $urandom_range(0, 9);
            if (sel < 7)       v = 11'($urandom_range(0, 95));
            else if (sel < 9)  v = 11'($urandom_range(160, 2047));
            else               v = 11'($urandom_range(0, 4) * 32);
            do_start(v);
        end

        begin
            int n = 0;
            while (sb.size() > 0 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("drain", sb.size() == 0, sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
